// File: rtl/mul_share_arb.sv
// Round-robin arbiter that shares one start/ack multiplier among N requesters.
// Define MUL_ARB_TIMEOUT_EN to add a WAIT_ACK watchdog that raises a sticky err.
module mul_share_arb #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   op_a,
   input  logic [N*W-1:0]   op_b,
   output logic [N-1:0]     grant,
   output logic [N-1:0]     done,
   output logic [2*W-1:0]   result,
   output logic             busy,
   output logic             err,
   output logic             mul_start,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_b,
   input  logic [2*W-1:0]   mul_r,
   input  logic             mul_ack
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
      $error("mul_share_arb: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_ACK, DONE} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [PW-1:0] sel;
   logic [PW-1:0] cand;
   logic          found;
   logic [N-1:0]  sel_onehot;
   logic [W-1:0]  sel_a;
   logic [W-1:0]  sel_b;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wcnt;
`else
   assign err = 1'b0;
`endif

   // First requester at or after ptr, wrapping modulo N, plus its operand slices.
   always_comb begin
      found      = 1'b0;
      sel        = '0;
      cand       = '0;
      sel_onehot = '0;
      sel_a      = '0;
      sel_b      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = PW'((32'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == PW'(i)) begin
            sel_onehot[i] = 1'b1;
            sel_a         = op_a[i*W +: W];
            sel_b         = op_b[i*W +: W];
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         done      <= '0;
         result    <= '0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         ptr       <= '0;
         gidx      <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         err       <= 1'b0;
         wcnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant     <= sel_onehot;
                  gidx      <= sel;
                  mul_a     <= sel_a;
                  mul_b     <= sel_b;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mul_start <= 1'b0;
               state     <= WAIT_CLR;
            end
            WAIT_CLR: begin
               // mul_ack may still show the previous product here; skip it.
`ifdef MUL_ARB_TIMEOUT_EN
               wcnt  <= '0;
`endif
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (mul_ack) begin
                  result <= mul_r;
                  done   <= grant;
                  state  <= DONE;
               end
`ifdef MUL_ARB_TIMEOUT_EN
               else if (wcnt == CW'(TIMEOUT - 1)) begin
                  result <= '0;
                  err    <= 1'b1;
                  done   <= grant;
                  state  <= DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            DONE: begin
               done  <= '0;
               grant <= '0;
               busy  <= 1'b0;
               ptr   <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
